pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Game sequencer for the pong graphics datapath. Consumes hit/miss events and the 60 Hz refresh tick.
//  Drives freeze/relaunch controls, ball-speed level, lives and BCD score back to the graph and text overlays.
//  Sits between the button inputs, the pong graph-animation block and the text/score display block.
// PARAMETERS
//  BALLS        3    lives per game (1..3)
//  TIMER_TICKS  120  refr_tick count of the hold timer (120 = 2 s at 60 Hz)
//  SPEED_STEP   4    consecutive-hit count that raises speed_level by 1
//  SPEED_MAX    3    saturation value of speed_level
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high
//  refr_tick    in   1  1-cycle pulse per frame, from graph block
//  btn_n        in   2  paddle buttons, active-low, already synchronised
//  hit          in   1  1-cycle pulse: paddle returned ball
//  miss         in   1  1-cycle pulse: ball passed right edge
//  gra_still    out  1  1 = freeze ball and paddle motion
//  ball_reload  out  1  1-cycle pulse: re-centre ball, clear velocity to +1/+1
//  text_state   out  2  00 start screen, 01 playing, 10 ball lost, 11 game over
//  balls_left   out  2  remaining lives
//  score        out  8  two BCD digits {tens,ones}
//  speed_level  out  2  ball speed increment for graph block (0..SPEED_MAX)
// BEHAVIOUR
//  Reset (async, immediate): state=NEWGAME, gra_still=1, ball_reload=0, text_state=00,
//   balls_left=BALLS, score=8'h00, speed_level=0, timer=0, hit counter=0.
//  Button press = any btn_n bit low, sampled every clk (not gated by refr_tick).
//  Timer: load TIMER_TICKS, decrement on refr_tick, timer_done when 0; never underflows.
//  FSM (registered outputs, update on clock edge after the cause):
//   NEWGAME: gra_still=1, text 00. Press -> PLAY; same edge: balls_left=BALLS, score=0,
//    speed_level=0, pulse ball_reload.
//   PLAY: gra_still=0, text 01. hit -> score+1 (BCD; ones 9->0 carries; 99 wraps to 00),
//    hit counter+1; at SPEED_STEP, counter->0 and speed_level+1, saturating at SPEED_MAX.
//    miss -> balls_left-1, hit counter->0, speed_level->0, load timer.
//    Then if balls_left was 1 -> OVER, else -> NEWBALL.
//   NEWBALL: gra_still=1, text 10. On timer_done and a press -> PLAY, pulse ball_reload.
//    Press before timer_done is ignored.
//   OVER: gra_still=1, text 11. On timer_done -> NEWGAME. Score is held until the next game starts.
//  Simultaneous hit & miss in one cycle: miss wins, hit discarded, score unchanged.
//  hit/miss outside PLAY are ignored. refr_tick concurrent with a state change: the timer load wins.
//  ball_reload is high exactly 1 cycle per launch, never in the same cycle as a state other than PLAY.
//  Reset mid-game: all state returns to reset values within the same cycle; no ball_reload pulse.
// CONFIGURATION
//  PONG_CTRL_PAUSE_EN defined: adds PAUSE state.
//   In PLAY, both btn_n low (after both had been high) -> PAUSE: gra_still=1, text 01, timer frozen,
//    hit/miss ignored.
//   In PAUSE, both released then both pressed again -> back to PLAY with no ball_reload.
//   Single-button presses in PAUSE are ignored.
//  Not defined: no PAUSE state; a both-button press is an ordinary press.
//   PLAY ignores buttons entirely.
// TESTING
//  1 reset, then btn_n=2'b10 for 1 clk -> PLAY, ball_reload 1 clk, balls_left=3, score=00, gra_still=0.
//  2 PLAY, 11 hit pulses -> score=8'h11; speed_level=2 after hits 4 and 8, stays 2 after hit 11.
//  3 PLAY, hit&miss same clk -> score unchanged, balls_left 3->2, speed_level=0, NEWBALL;
//    press at tick 60 ignored, press after 120 ticks -> PLAY.
//  4 three misses -> OVER, text 11; after 120 refr_ticks -> NEWGAME, text 00, score held.
//  5 99 hits -> score 8'h99, 100th hit -> 8'h00; speed_level saturates at 3.
//  6 reset asserted mid-NEWBALL timer -> outputs at reset values that cycle.
//    With PONG_CTRL_PAUSE_EN: btn_n=00 -> PAUSE; hit ignored; release, 00 -> PLAY.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------------------------
// pong_game_ctrl
//   Game sequencer for the pong graphics datapath. Takes hit/miss events from the graph block and
//   the per-frame refresh tick, and drives the freeze/relaunch controls, ball-speed level, lives
//   and BCD score back to the graph and text overlays.
//
//   Optional feature: define PONG_CTRL_PAUSE_EN to add a PAUSE state. From PLAY, a both-button
//   press pauses the game. From PAUSE, releasing both buttons and then pressing both again
//   resumes play. Without the macro, PLAY ignores the buttons.
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  asynchronous, active-high
//   refr_tick    in   1  1-cycle pulse per frame
//   btn_n        in   2  paddle buttons, active-low, already synchronised
//   hit          in   1  1-cycle pulse: paddle returned ball
//   miss         in   1  1-cycle pulse: ball passed right edge
//   gra_still    out  1  1 = freeze ball and paddle motion
//   ball_reload  out  1  1-cycle pulse: re-centre ball and reset its velocity
//   text_state   out  2  00 start, 01 playing, 10 ball lost, 11 game over
//   balls_left   out  2  remaining lives
//   score        out  8  two BCD digits {tens, ones}
//   speed_level  out  2  ball speed increment (0..SPEED_MAX)
// ---------------------------------------------------------------------------------------------
module pong_game_ctrl #(
    parameter int unsigned BALLS       = 3,
    parameter int unsigned TIMER_TICKS = 120,
    parameter int unsigned SPEED_STEP  = 4,
    parameter int unsigned SPEED_MAX   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refr_tick,
    input  logic [1:0] btn_n,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic       ball_reload,
    output logic [1:0] text_state,
    output logic [1:0] balls_left,
    output logic [7:0] score,
    output logic [1:0] speed_level
);

    localparam int unsigned TW = $clog2(TIMER_TICKS + 1);
    localparam int unsigned HW = $clog2(SPEED_STEP + 1);

    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMER_TICKS);
    localparam logic [HW-1:0] HIT_LAST   = HW'(SPEED_STEP - 1);
    localparam logic [1:0]    BALLS_INIT = 2'(BALLS);
    localparam logic [1:0]    SPEED_TOP  = 2'(SPEED_MAX);

    localparam logic [1:0] TXT_START = 2'b00;
    localparam logic [1:0] TXT_PLAY  = 2'b01;
    localparam logic [1:0] TXT_LOST  = 2'b10;
    localparam logic [1:0] TXT_OVER  = 2'b11;

    typedef enum logic [2:0] {
        StNewGame,
        StPlay,
        StNewBall,
        StOver
`ifdef PONG_CTRL_PAUSE_EN
        ,
        StPause
`endif
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [HW-1:0] hit_cnt;

    logic press;
    logic timer_done;

    assign press      = ~&btn_n;
    assign timer_done = (timer == '0);

`ifdef PONG_CTRL_PAUSE_EN
    // Set once both buttons have been seen released; a both-press only counts while armed.
    logic pause_arm;
    logic both_low;
    logic both_high;

    assign both_low  = (btn_n == 2'b00);
    assign both_high = (btn_n == 2'b11);
`endif

    // Two-digit BCD increment; 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        ones = v[3:0];
        tens = v[7:4];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StNewGame;
            gra_still   <= 1'b1;
            ball_reload <= 1'b0;
            text_state  <= TXT_START;
            balls_left  <= BALLS_INIT;
            score       <= 8'h00;
            speed_level <= 2'd0;
            timer       <= '0;
            hit_cnt     <= '0;
`ifdef PONG_CTRL_PAUSE_EN
            pause_arm   <= 1'b0;
`endif
        end else begin
            ball_reload <= 1'b0;

            unique case (state)
                StNewGame: begin
                    if (press) begin
                        state       <= StPlay;
                        gra_still   <= 1'b0;
                        text_state  <= TXT_PLAY;
                        balls_left  <= BALLS_INIT;
                        score       <= 8'h00;
                        speed_level <= 2'd0;
                        hit_cnt     <= '0;
                        ball_reload <= 1'b1;
`ifdef PONG_CTRL_PAUSE_EN
                        pause_arm   <= 1'b0;
`endif
                    end
                end

                StPlay: begin
                    // Miss outranks a same-cycle hit; the hit is dropped.
                    if (miss) begin
                        balls_left  <= balls_left - 2'd1;
                        hit_cnt     <= '0;
                        speed_level <= 2'd0;
                        timer       <= TIMER_LOAD;
                        gra_still   <= 1'b1;
                        if (balls_left == 2'd1) begin
                            state      <= StOver;
                            text_state <= TXT_OVER;
                        end else begin
                            state      <= StNewBall;
                            text_state <= TXT_LOST;
                        end
                    end else begin
                        if (hit) begin
                            score <= bcd_inc(score);
                            if (hit_cnt == HIT_LAST) begin
                                hit_cnt <= '0;
                                if (speed_level != SPEED_TOP) begin
                                    speed_level <= speed_level + 2'd1;
                                end
                            end else begin
                                hit_cnt <= hit_cnt + 1'b1;
                            end
                        end
`ifdef PONG_CTRL_PAUSE_EN
                        if (both_high) begin
                            pause_arm <= 1'b1;
                        end else if (both_low && pause_arm) begin
                            pause_arm <= 1'b0;
                            state     <= StPause;
                            gra_still <= 1'b1;
                        end
`endif
                    end
                end

                StNewBall: begin
                    if (timer_done && press) begin
                        state       <= StPlay;
                        gra_still   <= 1'b0;
                        text_state  <= TXT_PLAY;
                        ball_reload <= 1'b1;
`ifdef PONG_CTRL_PAUSE_EN
                        pause_arm   <= 1'b0;
`endif
                    end else if (refr_tick && !timer_done) begin
                        timer <= timer - 1'b1;
                    end
                end

                StOver: begin
                    if (timer_done) begin
                        state      <= StNewGame;
                        gra_still  <= 1'b1;
                        text_state <= TXT_START;
                    end else if (refr_tick) begin
                        timer <= timer - 1'b1;
                    end
                end

`ifdef PONG_CTRL_PAUSE_EN
                // Timer, hit and miss are all frozen here; text stays at "playing".
                StPause: begin
                    if (both_high) begin
                        pause_arm <= 1'b1;
                    end else if (both_low && pause_arm) begin
                        pause_arm <= 1'b0;
                        state     <= StPlay;
                        gra_still <= 1'b0;
                    end
                end
`endif

                default: begin
                    state      <= StNewGame;
                    gra_still  <= 1'b1;
                    text_state <= TXT_START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_pong_game_ctrl
//   Directed self-checking bench for pong_game_ctrl with default parameters
//   (BALLS=3, TIMER_TICKS=120, SPEED_STEP=4, SPEED_MAX=3). Inputs change 1 ns after the rising
//   edge and outputs are sampled at that same point. Pause checks are compiled when
//   PONG_CTRL_PAUSE_EN is defined.
// ---------------------------------------------------------------------------------------------
module tb_pong_game_ctrl;

    logic       clk;
    logic       reset;
    logic       refr_tick;
    logic [1:0] btn_n;
    logic       hit;
    logic       miss;
    logic       gra_still;
    logic       ball_reload;
    logic [1:0] text_state;
    logic [1:0] balls_left;
    logic [7:0] score;
    logic [1:0] speed_level;

    int n_vec;
    int n_bad;

    pong_game_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .refr_tick   (refr_tick),
        .btn_n       (btn_n),
        .hit         (hit),
        .miss        (miss),
        .gra_still   (gra_still),
        .ball_reload (ball_reload),
        .text_state  (text_state),
        .balls_left  (balls_left),
        .score       (score),
        .speed_level (speed_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_hit();
        hit = 1'b1;
        step();
        hit = 1'b0;
    endtask

    task automatic do_miss();
        miss = 1'b1;
        step();
        miss = 1'b0;
    endtask

    task automatic do_press(input logic [1:0] b);
        btn_n = b;
        step();
        btn_n = 2'b11;
    endtask

    task automatic do_ticks(input int n);
        refr_tick = 1'b1;
        repeat (n) step();
        refr_tick = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        refr_tick = 1'b0;
        btn_n     = 2'b11;
        hit       = 1'b0;
        miss      = 1'b0;
        repeat (2) step();

        // 1: reset state, then launch
        check("rst_still", gra_still, 1);
        check("rst_reload", ball_reload, 0);
        check("rst_text", text_state, 2'b00);
        check("rst_balls", balls_left, 3);
        check("rst_score", score, 8'h00);
        check("rst_speed", speed_level, 0);
        reset = 1'b0;
        step();
        check("idle_text", text_state, 2'b00);
        do_press(2'b10);
        check("launch_text", text_state, 2'b01);
        check("launch_still", gra_still, 0);
        check("launch_reload", ball_reload, 1);
        check("launch_balls", balls_left, 3);
        check("launch_score", score, 8'h00);
        step();
        check("reload_1cyc", ball_reload, 0);

        // 2: eleven hits, speed steps at hits 4 and 8
        for (int i = 1; i <= 11; i++) begin
            do_hit();
            if (i == 4) check("speed_hit4", speed_level, 1);
            if (i == 8) check("speed_hit8", speed_level, 2);
            if (i == 10) check("score_hit10", score, 8'h10);
        end
        check("score_hit11", score, 8'h11);
        check("speed_hit11", speed_level, 2);

        // 3: hit and miss together, miss wins
        hit = 1'b1;
        do_miss();
        hit = 1'b0;
        check("hm_score", score, 8'h11);
        check("hm_balls", balls_left, 2);
        check("hm_speed", speed_level, 0);
        check("hm_text", text_state, 2'b10);
        check("hm_still", gra_still, 1);
        do_hit();
        check("hit_outside_play", score, 8'h11);
        do_ticks(60);
        do_press(2'b01);
        check("early_press", text_state, 2'b10);
        do_ticks(59);
        do_press(2'b10);
        check("press_tick119", text_state, 2'b10);
        do_ticks(1);
        check("timer_done_wait", text_state, 2'b10);
        do_press(2'b10);
        check("relaunch_text", text_state, 2'b01);
        check("relaunch_reload", ball_reload, 1);
        check("relaunch_balls", balls_left, 2);

        // 4: remaining lives lost -> OVER -> NEWGAME with score held
        do_miss();
        check("miss2_balls", balls_left, 1);
        do_ticks(120);
        do_press(2'b01);
        check("play3_text", text_state, 2'b01);
        do_miss();
        check("over_text", text_state, 2'b11);
        check("over_balls", balls_left, 0);
        check("over_still", gra_still, 1);
        do_ticks(119);
        check("over_tick119", text_state, 2'b11);
        do_ticks(1);
        check("over_tick120", text_state, 2'b11);
        step();
        check("newgame_text", text_state, 2'b00);
        check("newgame_score", score, 8'h11);

        // 5: 99 hits, then wrap
        do_press(2'b00);
        check("game2_score", score, 8'h00);
        check("game2_balls", balls_left, 3);
        for (int i = 0; i < 99; i++) do_hit();
        check("score_99", score, 8'h99);
        check("speed_sat", speed_level, 3);
        do_hit();
        check("score_wrap", score, 8'h00);

        // 6: asynchronous reset mid-NEWBALL
        do_miss();
        check("nb_balls", balls_left, 2);
        do_ticks(10);
        #3;
        reset = 1'b1;
        #1;
        check("arst_text", text_state, 2'b00);
        check("arst_still", gra_still, 1);
        check("arst_reload", ball_reload, 0);
        check("arst_balls", balls_left, 3);
        check("arst_speed", speed_level, 0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_text", text_state, 2'b00);

`ifdef PONG_CTRL_PAUSE_EN
        do_press(2'b10);
        step();
        btn_n = 2'b00;
        step();
        check("pause_still", gra_still, 1);
        check("pause_text", text_state, 2'b01);
        do_hit();
        check("pause_hit", score, 8'h00);
        btn_n = 2'b11;
        step();
        btn_n = 2'b01;
        step();
        check("pause_single", gra_still, 1);
        btn_n = 2'b11;
        step();
        btn_n = 2'b00;
        step();
        btn_n = 2'b11;
        check("resume_still", gra_still, 0);
        check("resume_reload", ball_reload, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
